// File: rtl/button_conditioner.sv
// Purpose : N-channel push-button front end: sync, debounce, edge, long-press and auto-repeat pulses.
// Latency : 2 clk sync, then level/press on the DB_TICKS-th consecutive differing sample tick (registered).
// Backpress: none; outputs are free-running pulses/levels, the consumer must sample every clk.
//
// Ports:
//   clk          system clock, the only clock
//   rst          asynchronous active-low reset
//   btn[N]       raw bouncy button inputs, asynchronous to clk
//   repeat_en    1 = auto-repeat pulses enabled on all channels
//   level[N]     debounced button state
//   press[N]     1-clk pulse on level 0->1
//   release_pls  1-clk pulse on level 1->0 ("release" is a reserved word)
//   hold[N]      1-clk pulse when the long-press threshold is reached
//   repeat_pls   1-clk auto-repeat pulse ("repeat" is a reserved word)
module button_conditioner #(
    parameter int N            = 4,
    parameter int CLK_DIV      = 250_000,
    parameter int DB_TICKS     = 4,
    parameter int HOLD_TICKS   = 200,
    parameter int REPEAT_TICKS = 50
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] btn,
    input  logic         repeat_en,
    output logic [N-1:0] level,
    output logic [N-1:0] press,
    output logic [N-1:0] release_pls,
    output logic [N-1:0] hold,
    output logic [N-1:0] repeat_pls
);

    localparam int CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int DW   = (DB_TICKS > 1) ? $clog2(DB_TICKS) : 1;
    localparam int HMAX = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
    localparam int HW   = (HMAX > 1) ? $clog2(HMAX) : 1;

    localparam logic [CW-1:0] DIV_LAST  = CW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DB_LAST   = DW'(DB_TICKS - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);
    localparam logic [HW-1:0] RPT_LAST  = HW'(REPEAT_TICKS - 1);

    typedef enum logic [1:0] {
        ST_UP   = 2'd0,
        ST_DOWN = 2'd1,
        ST_RPT  = 2'd2
    } state_e;

    // shared sample-enable divider
    logic [CW-1:0] div_cnt_q, div_cnt_d;
    logic          tick;

    // per-channel state
    logic [N-1:0]  sync1_q, sync1_d;
    logic [N-1:0]  sync2_q, sync2_d;
    logic [DW-1:0] dcnt_q [N];
    logic [DW-1:0] dcnt_d [N];
    logic [N-1:0]  level_q, level_d;
    logic [N-1:0]  rise, fall;
    state_e        state_q [N];
    state_e        state_d [N];
    logic [HW-1:0] hcnt_q [N];
    logic [HW-1:0] hcnt_d [N];
    logic [N-1:0]  press_q, press_d;
    logic [N-1:0]  release_q, release_d;
    logic [N-1:0]  hold_q, hold_d;
    logic [N-1:0]  repeat_q, repeat_d;

    assign tick = (div_cnt_q == DIV_LAST);

    always_comb begin
        div_cnt_d = tick ? '0 : div_cnt_q + CW'(1);
        sync1_d   = btn;
        sync2_d   = sync1_q;
    end

    // Debounce: the counter only moves on ticks, so level can only change on a tick.
    // rise/fall are the toggle qualifiers for this cycle; they feed both the edge
    // pulse registers and the hold FSM so all three update on the same edge.
    always_comb begin
        dcnt_d  = dcnt_q;
        level_d = level_q;
        rise    = '0;
        fall    = '0;
        for (int i = 0; i < N; i++) begin
            if (tick) begin
                if (sync2_q[i] == level_q[i]) begin
                    dcnt_d[i] = '0;
                end else if (dcnt_q[i] == DB_LAST) begin
                    dcnt_d[i]  = '0;
                    level_d[i] = ~level_q[i];
                    rise[i]    = ~level_q[i];
                    fall[i]    = level_q[i];
                end else begin
                    dcnt_d[i] = dcnt_q[i] + DW'(1);
                end
            end
        end
        press_d   = rise;
        release_d = fall;
    end

    // Hold / repeat FSM. Release has priority over everything, so a tick that
    // coincides with release never produces hold or repeat. The press cycle moves
    // UP->DOWN without counting, so the first counted tick is the next one.
    always_comb begin
        state_d  = state_q;
        hcnt_d   = hcnt_q;
        hold_d   = '0;
        repeat_d = '0;
        for (int i = 0; i < N; i++) begin
            if (fall[i]) begin
                state_d[i] = ST_UP;
                hcnt_d[i]  = '0;
            end else begin
                case (state_q[i])
                    ST_UP: begin
                        if (rise[i]) begin
                            state_d[i] = ST_DOWN;
                            hcnt_d[i]  = '0;
                        end
                    end
                    ST_DOWN: begin
                        if (tick) begin
                            if (hcnt_q[i] == HOLD_LAST) begin
                                hold_d[i]  = 1'b1;
                                state_d[i] = ST_RPT;
                                hcnt_d[i]  = '0;
                            end else begin
                                hcnt_d[i] = hcnt_q[i] + HW'(1);
                            end
                        end
                    end
                    ST_RPT: begin
                        // the repeat grid keeps running while repeat_en is low so
                        // enabling it later lands on the same cadence
                        if (tick) begin
                            if (hcnt_q[i] == RPT_LAST) begin
                                repeat_d[i] = repeat_en;
                                hcnt_d[i]   = '0;
                            end else begin
                                hcnt_d[i] = hcnt_q[i] + HW'(1);
                            end
                        end
                    end
                    default: begin
                        state_d[i] = ST_UP;
                        hcnt_d[i]  = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt_q <= '0;
            sync1_q   <= '0;
            sync2_q   <= '0;
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            hold_q    <= '0;
            repeat_q  <= '0;
            for (int i = 0; i < N; i++) begin
                dcnt_q[i]  <= '0;
                hcnt_q[i]  <= '0;
                state_q[i] <= ST_UP;
            end
        end else begin
            div_cnt_q <= div_cnt_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            hold_q    <= hold_d;
            repeat_q  <= repeat_d;
            for (int i = 0; i < N; i++) begin
                dcnt_q[i]  <= dcnt_d[i];
                hcnt_q[i]  <= hcnt_d[i];
                state_q[i] <= state_d[i];
            end
        end
    end

    assign level       = level_q;
    assign press       = press_q;
    assign release_pls = release_q;
    assign hold        = hold_q;
    assign repeat_pls  = repeat_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Purpose : directed bench for button_conditioner (N=2, CLK_DIV=4, DB_TICKS=3, HOLD_TICKS=5, REPEAT_TICKS=2).
// Latency : expected events are stamped with the clk-edge index counted from reset release.
// Backpress: n/a; a monitor pops the expected-event queue whenever any pulse output is high.
module tb_button_conditioner;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] btn;
    logic       repeat_en;
    logic [1:0] level, press, rel_p, hold, rpt_p;
    logic [9:0] outs;

    always #5 clk = ~clk;

    button_conditioner #(
        .N(2), .CLK_DIV(4), .DB_TICKS(3), .HOLD_TICKS(5), .REPEAT_TICKS(2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn         (btn),
        .repeat_en   (repeat_en),
        .level       (level),
        .press       (press),
        .release_pls (rel_p),
        .hold        (hold),
        .repeat_pls  (rpt_p)
    );

    assign outs = {level, press, rel_p, hold, rpt_p};

    // edge index since reset release: after edge k this reads k
    int edge_n;
    always @(posedge clk or negedge rst) begin
        if (!rst) edge_n <= 0;
        else      edge_n <= edge_n + 1;
    end

    typedef struct packed {
        int         at;
        logic [1:0] lvl;
        logic [1:0] prs;
        logic [1:0] rel;
        logic [1:0] hld;
        logic [1:0] rpt;
    } ev_t;

    ev_t exp_q[$];
    ev_t mon_act, mon_exp;
    int  n_checks = 0;
    int  n_errors = 0;

    function automatic void expect_ev(input int at, input logic [1:0] lvl, input logic [1:0] prs,
                                      input logic [1:0] rel, input logic [1:0] hld, input logic [1:0] rpt);
        ev_t e;
        e = '{at: at, lvl: lvl, prs: prs, rel: rel, hld: hld, rpt: rpt};
        exp_q.push_back(e);
    endfunction

    function automatic void check_outs(input string name, input logic [9:0] req);
        n_checks++;
        if (outs !== req) begin
            n_errors++;
            $display("FAIL %s: actual {lvl,prs,rel,hld,rpt}=%b, required %b", name, outs, req);
        end
    endfunction

    function automatic void check_drained(input string name);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL %s: actual %0d expected events still pending, required 0 (next at edge %0d)",
                     name, exp_q.size(), exp_q[0].at);
        end
        exp_q.delete();
    endfunction

    // wait for the negedge that follows edge k (k must lie ahead of the current edge)
    task automatic at_edge(input int k);
        int guard;
        guard = 0;
        @(negedge clk);
        while (edge_n != k && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (edge_n != k) begin
            n_checks++;
            n_errors++;
            $display("FAIL at_edge_timeout: actual edge %0d, required %0d", edge_n, k);
        end
    endtask

    // leaves the caller on the negedge where rst rises; the next posedge is edge 1
    task automatic do_reset(input logic [1:0] b, input logic ren);
        @(negedge clk);
        rst       = 1'b0;
        btn       = b;
        repeat_en = ren;
        repeat (2) @(negedge clk);
        check_outs("reset_outputs", 10'b0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst       = 1'b0;
        btn       = 2'b00;
        repeat_en = 1'b0;

        fork
            forever begin
                @(negedge clk);
                if ((press | rel_p | hold | rpt_p) != 2'b00) begin
                    mon_act = '{at: edge_n, lvl: level, prs: press, rel: rel_p, hld: hold, rpt: rpt_p};
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_errors++;
                        $display("FAIL unexpected_pulse: actual at=%0d lvl=%b prs=%b rel=%b hld=%b rpt=%b, required no pulse",
                                 mon_act.at, mon_act.lvl, mon_act.prs, mon_act.rel, mon_act.hld, mon_act.rpt);
                    end else begin
                        mon_exp = exp_q.pop_front();
                        if (mon_act !== mon_exp) begin
                            n_errors++;
                            $display("FAIL event: actual at=%0d lvl=%b prs=%b rel=%b hld=%b rpt=%b, required at=%0d lvl=%b prs=%b rel=%b hld=%b rpt=%b",
                                     mon_act.at, mon_act.lvl, mon_act.prs, mon_act.rel, mon_act.hld, mon_act.rpt,
                                     mon_exp.at, mon_exp.lvl, mon_exp.prs, mon_exp.rel, mon_exp.hld, mon_exp.rpt);
                        end
                    end
                end
            end
        join_none

        // 1: buttons held through reset, then a quick release of both
        do_reset(2'b11, 1'b1);
        expect_ev(12, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00);
        expect_ev(24, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00);
        at_edge(13);
        btn = 2'b00;
        at_edge(40);
        check_drained("t1_drained");

        // 2: bounce rejection, then a clean step
        do_reset(2'b00, 1'b1);
        for (int m = 0; m < 20; m++) begin
            if (m > 0) at_edge(5 * m);
            btn[0] = (m % 2 == 0);
        end
        at_edge(99);
        check_outs("t2_bounce_level", 10'b0);
        expect_ev(112, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00);
        at_edge(100);
        btn[0] = 1'b1;
        at_edge(118);
        check_drained("t2_drained");

        // 3: long press with auto-repeat, then release
        do_reset(2'b00, 1'b1);
        btn = 2'b01;
        expect_ev(12, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00);
        expect_ev(32, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00);
        expect_ev(40, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01);
        expect_ev(48, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01);
        expect_ev(56, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01);
        expect_ev(64, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01);
        expect_ev(72, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
        at_edge(58);
        btn = 2'b00;
        at_edge(100);
        check_drained("t3_drained");

        // 4: repeat disabled, then enabled mid-RPT on the existing grid
        do_reset(2'b00, 1'b0);
        btn = 2'b01;
        expect_ev(12, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00);
        expect_ev(32, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00);
        at_edge(50);
        check_drained("t4_no_repeat");
        repeat_en = 1'b1;
        expect_ev(56, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01);
        expect_ev(64, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01);
        at_edge(66);
        check_drained("t4_drained");

        // 5: channel independence, simultaneous release
        do_reset(2'b00, 1'b1);
        btn = 2'b01;
        expect_ev(12, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00);
        expect_ev(20, 2'b11, 2'b10, 2'b00, 2'b00, 2'b00);
        expect_ev(32, 2'b11, 2'b00, 2'b00, 2'b01, 2'b00);
        expect_ev(40, 2'b11, 2'b00, 2'b00, 2'b10, 2'b01);
        expect_ev(48, 2'b11, 2'b00, 2'b00, 2'b00, 2'b11);
        expect_ev(56, 2'b11, 2'b00, 2'b00, 2'b00, 2'b11);
        expect_ev(64, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00);
        at_edge(8);
        btn = 2'b11;
        at_edge(50);
        btn = 2'b00;
        at_edge(80);
        check_drained("t5_drained");

        // 6: async reset mid-RPT, button still held afterwards
        do_reset(2'b00, 1'b1);
        btn = 2'b01;
        expect_ev(12, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00);
        expect_ev(32, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00);
        expect_ev(40, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01);
        at_edge(42);
        @(posedge clk);
        #2 rst = 1'b0;
        #1 check_outs("t6_async_clear", 10'b0);
        check_drained("t6_pre_reset");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        expect_ev(12, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00);
        expect_ev(32, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00);
        at_edge(36);
        check_drained("t6_drained");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
